// File: rtl/i2s_master.sv
// I2S bus master: divides clk into MCLK/BCLK/WCLK and serialises stereo TX sample pairs onto sdout.
// Defining I2S_RX_EN adds the sdin deserialiser and the rx_l/rx_r/rx_valid ports.
module i2s_master #(
  parameter int MCLK_HALF = 4,
  parameter int BCLK_HALF = 32,
  parameter int SLOT_W    = 16,
  parameter int SAMPLE_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  output logic                mclk,
  output logic                bclk,
  output logic                wclk,
  output logic                sdout,
  input  logic [SAMPLE_W-1:0] tx_l,
  input  logic [SAMPLE_W-1:0] tx_r,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                tx_underrun
`ifdef I2S_RX_EN
  ,
  input  logic                sdin,
  output logic [SAMPLE_W-1:0] rx_l,
  output logic [SAMPLE_W-1:0] rx_r,
  output logic                rx_valid
`endif
);

  localparam int FRAME = 2 * SLOT_W;
  localparam int MC_W  = $clog2(MCLK_HALF + 1);
  localparam int BC_W  = $clog2(BCLK_HALF + 1);
  localparam int POS_W = $clog2(FRAME);

  localparam logic [MC_W-1:0]  MC_LAST  = MC_W'(MCLK_HALF - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BCLK_HALF - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME - 1);
  localparam logic [POS_W-1:0] POS_RSL  = POS_W'(SLOT_W);

  // Sample placed MSB-first in its slot, zero-padded below.
  function automatic logic [SLOT_W-1:0] slot_word(input logic [SAMPLE_W-1:0] s);
    return SLOT_W'(s) << (SLOT_W - SAMPLE_W);
  endfunction

  logic [MC_W-1:0]     mclk_cnt;
  logic [BC_W-1:0]     bclk_cnt;
  logic [POS_W-1:0]    pos;
  logic [POS_W-1:0]    pos_nxt;
  logic [FRAME-1:0]    frame_sr;
  logic [FRAME-1:0]    frame_word;
  logic                hold_vld;
  logic [SAMPLE_W-1:0] hold_l;
  logic [SAMPLE_W-1:0] hold_r;
  logic                bclk_tick;
  logic                fall_stb;
  logic                load_stb;
  logic                accept;

  always_comb begin
    bclk_tick  = en && (bclk_cnt == BC_LAST);
    fall_stb   = bclk_tick && bclk;
    pos_nxt    = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
    load_stb   = fall_stb && (pos == '0);
    accept     = tx_valid && !hold_vld;
    frame_word = hold_vld ? {slot_word(hold_l), slot_word(hold_r)} : '0;
  end

  assign tx_ready = !hold_vld;

  // MCLK divider: free-running, independent of en
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mclk_cnt <= '0;
      mclk     <= 1'b0;
    end else if (mclk_cnt == MC_LAST) begin
      mclk_cnt <= '0;
      mclk     <= ~mclk;
    end else begin
      mclk_cnt <= mclk_cnt + MC_W'(1);
    end
  end

  // BCLK divider, frame position and TX shifter; all collapse to idle while en is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_cnt <= '0;
      bclk     <= 1'b0;
      pos      <= '0;
      wclk     <= 1'b0;
      sdout    <= 1'b0;
      frame_sr <= '0;
    end else if (!en) begin
      bclk_cnt <= '0;
      bclk     <= 1'b0;
      pos      <= '0;
      wclk     <= 1'b0;
      sdout    <= 1'b0;
      frame_sr <= '0;
    end else begin
      if (bclk_tick) begin
        bclk_cnt <= '0;
        bclk     <= ~bclk;
      end else begin
        bclk_cnt <= bclk_cnt + BC_W'(1);
      end
      if (fall_stb) begin
        pos  <= pos_nxt;
        wclk <= (pos_nxt >= POS_RSL);
        if (load_stb) begin
          sdout    <= frame_word[FRAME-1];
          frame_sr <= frame_word << 1;
        end else begin
          sdout    <= frame_sr[FRAME-1];
          frame_sr <= frame_sr << 1;
        end
      end
    end
  end

  // Holding register control; a load in the accept cycle sees the pre-accept contents
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_vld    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= load_stb && !hold_vld;
      if (accept) begin
        hold_vld <= 1'b1;
      end else if (load_stb) begin
        hold_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_l <= tx_l;
      hold_r <= tx_r;
    end
  end

`ifdef I2S_RX_EN
  logic                sdin_p1;
  logic                sdin_p2;
  logic [SAMPLE_W-1:0] rx_sh_l;
  logic [SAMPLE_W-1:0] rx_sh_r;
  logic [SAMPLE_W-1:0] rx_sh_l_nxt;
  logic [SAMPLE_W-1:0] rx_sh_r_nxt;
  logic                rx_armed;
  logic                rise_stb;
  logic                cap_l;
  logic                cap_r;
  logic                rx_done;

  always_comb begin
    rise_stb    = bclk_tick && !bclk;
    cap_l       = rise_stb && (int'(pos) >= 1) && (int'(pos) <= SAMPLE_W);
    cap_r       = rise_stb && (((pos > POS_RSL) && (int'(pos) <= SLOT_W + SAMPLE_W)) ||
                               ((SAMPLE_W == SLOT_W) && (pos == '0)));
    rx_done     = rise_stb && (pos == '0);
    rx_sh_l_nxt = (rx_sh_l << 1) | SAMPLE_W'(sdin_p2);
    rx_sh_r_nxt = (rx_sh_r << 1) | SAMPLE_W'(sdin_p2);
  end

  // sdin synchroniser stages p1/p2
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdin_p1 <= 1'b0;
      sdin_p2 <= 1'b0;
    end else begin
      sdin_p1 <= sdin;
      sdin_p2 <= sdin_p1;
    end
  end

  // Deserialiser; rx_armed blocks the output until a full frame has been captured since enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sh_l  <= '0;
      rx_sh_r  <= '0;
      rx_armed <= 1'b0;
      rx_l     <= '0;
      rx_r     <= '0;
      rx_valid <= 1'b0;
    end else if (!en) begin
      rx_sh_l  <= '0;
      rx_sh_r  <= '0;
      rx_armed <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= rx_done && rx_armed;
      if (cap_l) rx_sh_l <= rx_sh_l_nxt;
      if (cap_r) rx_sh_r <= rx_sh_r_nxt;
      if (rise_stb && (pos == POS_W'(1))) rx_armed <= 1'b1;
      if (rx_done && rx_armed) begin
        rx_l <= rx_sh_l;
        rx_r <= cap_r ? rx_sh_r_nxt : rx_sh_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_i2s_master.sv
// Bench for i2s_master: per-cycle comparison against a timing/arithmetic reference model,
// directed frame checks, underrun, en drop/re-enable and asynchronous reset; RX loopback when I2S_RX_EN.
module tb_i2s_master;

  localparam int MH  = 4;
  localparam int BH  = 4;
`ifdef I2S_RX_EN
  localparam int SW  = 32;
  localparam int SMW = 24;
  localparam logic [SMW-1:0] DL = 24'h123456;
  localparam logic [SMW-1:0] DR = 24'hFEDCBA;
`else
  localparam int SW  = 16;
  localparam int SMW = 16;
  localparam logic [SMW-1:0] DL = 16'hA5C3;
  localparam logic [SMW-1:0] DR = 16'h0F0F;
`endif
  localparam int FRAME_CYC = 4 * BH * SW;
  localparam int LIMIT     = 3 * FRAME_CYC;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           en;
  logic           mclk, bclk, wclk, sdout;
  logic [SMW-1:0] tx_l, tx_r;
  logic           tx_valid;
  logic           tx_ready, tx_underrun;
`ifdef I2S_RX_EN
  logic           sdin;
  logic [SMW-1:0] rx_l, rx_r;
  logic           rx_valid;
  assign sdin = sdout;
`endif

  always #5 clk = ~clk;

  i2s_master #(.MCLK_HALF(MH), .BCLK_HALF(BH), .SLOT_W(SW), .SAMPLE_W(SMW)) dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .mclk(mclk), .bclk(bclk), .wclk(wclk), .sdout(sdout),
    .tx_l(tx_l), .tx_r(tx_r), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun)
`ifdef I2S_RX_EN
    , .sdin(sdin), .rx_l(rx_l), .rx_r(rx_r), .rx_valid(rx_valid)
`endif
  );

  int n_cmp = 0;
  int n_mis = 0;

  // reference model state
  int             cyc, en_n;
  bit             held;
  logic [SMW-1:0] held_l, held_r, cur_l, cur_r;
  bit             exp_under, exp_rxv;
  logic [SW-1:0]  rec_l, rec_r;
  logic           acc_sd;
  int             acc_und;
  logic [SMW-1:0] sv_l, sv_r;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_falls();
    return en_n / (2 * BH);
  endfunction

  function automatic int m_pos();
    return m_falls() % (2 * SW);
  endfunction

  function automatic logic slot_bit(input logic [SMW-1:0] s, input int k);
    int pad;
    pad = SW - SMW;
    if (k < pad) return 1'b0;
    return s[k - pad];
  endfunction

  function automatic logic exp_sd();
    int p;
    if (m_falls() == 0) return 1'b0;
    p = m_pos();
    if (p >= 1 && p <= SW) return slot_bit(cur_l, SW - p);
    if (p == 0) p = 2 * SW;
    return slot_bit(cur_r, 2 * SW - p);
  endfunction

  task automatic model_reset();
    cyc = 0; en_n = 0; held = 0;
    held_l = '0; held_r = '0; cur_l = '0; cur_r = '0;
  endtask

  task automatic step();
    bit acc;
    int p, pp;
    @(posedge clk);
    cyc++;
    en_n = en ? en_n + 1 : 0;
    acc = tx_valid && !held;
    exp_under = 0;
    exp_rxv = 0;
    if (en && en_n % (2 * BH) == 0 && m_pos() == 1) begin
      if (held) begin
        cur_l = held_l; cur_r = held_r;
      end else begin
        cur_l = '0; cur_r = '0; exp_under = 1;
      end
      held = 0;
    end
    if (acc) begin
      held = 1; held_l = tx_l; held_r = tx_r;
    end
    if (en && en_n % (2 * BH) == BH && m_pos() == 0 && m_falls() >= 2 * SW) exp_rxv = 1;
    #1;
    check("mclk", 64'(mclk), 64'((cyc / MH) % 2));
    check("bclk", 64'(bclk), 64'((en_n / BH) % 2));
    check("wclk", 64'(wclk), 64'(m_pos() >= SW));
    check("sdout", 64'(sdout), 64'(exp_sd()));
    check("tx_ready", 64'(tx_ready), 64'(!held));
    check("tx_underrun", 64'(tx_underrun), 64'(exp_under));
`ifdef I2S_RX_EN
    check("rx_valid", 64'(rx_valid), 64'(exp_rxv));
    if (exp_rxv) begin
      check("rx_l", 64'(rx_l), 64'(cur_l));
      check("rx_r", 64'(rx_r), 64'(cur_r));
    end
`endif
    acc_sd  = acc_sd | sdout;
    acc_und = acc_und + int'(tx_underrun);
    if (en_n > 0 && en_n % (2 * BH) == 0) begin
      p = m_pos();
      if (p >= 1 && p <= SW) rec_l[SW - p] = sdout;
      else begin
        pp = (p == 0) ? 2 * SW : p;
        rec_r[2 * SW - pp] = sdout;
      end
    end
  endtask

  task automatic run_until_pos(input int p);
    int g = 0;
    while (m_pos() != p && g < LIMIT) begin
      step();
      g++;
    end
    check("bound_pos", 64'(g < LIMIT), 64'(1));
  endtask

  task automatic run_until_falls(input int f);
    int g = 0;
    while (m_falls() != f && g < LIMIT) begin
      step();
      g++;
    end
    check("bound_falls", 64'(g < LIMIT), 64'(1));
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      tx_valid = ($urandom_range(0, 9) == 0);
      tx_l = SMW'($urandom);
      tx_r = SMW'($urandom);
      step();
    end
    tx_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1; en = 1'b0; tx_valid = 1'b0; tx_l = '0; tx_r = '0;
    acc_sd = 1'b0; acc_und = 0; rec_l = '0; rec_r = '0;
    model_reset();
    #2 reset_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mclk", 64'(mclk), 64'(0));
    check("rst_bclk", 64'(bclk), 64'(0));
    check("rst_wclk", 64'(wclk), 64'(0));
    check("rst_sdout", 64'(sdout), 64'(0));
    check("rst_ready", 64'(tx_ready), 64'(1));
    check("rst_under", 64'(tx_underrun), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // directed frame
    en = 1'b1; tx_valid = 1'b1; tx_l = DL; tx_r = DR;
    step();
    tx_valid = 1'b0;
    run_until_falls(2 * SW);
    check("dir_l", 64'(rec_l >> (SW - SMW)), 64'(DL));
    check("dir_r", 64'(rec_r >> (SW - SMW)), 64'(DR));

    // one frame with nothing held
    acc_und = 0;
    run_until_falls(2 * SW + 1);
    acc_sd = 1'b0;
    run_until_falls(4 * SW);
    check("under_sdout", 64'(acc_sd), 64'(0));
    check("under_pulses", 64'(acc_und), 64'(1));

    run_random(8 * FRAME_CYC);

    // en dropped at pos 9 with a pair held
    run_until_pos(3);
    tx_valid = 1'b1; tx_l = SMW'($urandom); tx_r = SMW'($urandom);
    step();
    tx_valid = 1'b0;
    sv_l = held_l; sv_r = held_r;
    run_until_pos(9);
    en = 1'b0;
    step();
    check("drop_bclk", 64'(bclk), 64'(0));
    check("drop_wclk", 64'(wclk), 64'(0));
    check("drop_sdout", 64'(sdout), 64'(0));
    check("drop_held", 64'(tx_ready), 64'(0));
    repeat (5) step();
    en = 1'b1;
    run_until_falls(2 * SW);
    check("reen_l", 64'(rec_l >> (SW - SMW)), 64'(sv_l));
    check("reen_r", 64'(rec_r >> (SW - SMW)), 64'(sv_r));

    // asynchronous reset in the right slot with a pair held
    run_until_pos(SW + 2);
    tx_valid = 1'b1; tx_l = SMW'($urandom); tx_r = SMW'($urandom);
    step();
    tx_valid = 1'b0;
    run_until_pos(SW + 5);
    #2 reset_n = 1'b0;
    #1;
    check("arst_mclk", 64'(mclk), 64'(0));
    check("arst_bclk", 64'(bclk), 64'(0));
    check("arst_wclk", 64'(wclk), 64'(0));
    check("arst_sdout", 64'(sdout), 64'(0));
    check("arst_ready", 64'(tx_ready), 64'(1));
`ifdef I2S_RX_EN
    check("arst_rx_valid", 64'(rx_valid), 64'(0));
    check("arst_rx_l", 64'(rx_l), 64'(0));
`endif
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    step();
    check("post_rst_ready", 64'(tx_ready), 64'(1));
    run_random(2 * FRAME_CYC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
